// File: rtl/i2c_bit_ctrl.sv
// Byte-level I2C master sequencer: START / WRITE / READ / STOP, one bus phase per divider tick.
// Drives open-drain pull-down enables for SCL/SDA and reports received byte and ACK status.
module i2c_bit_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ack,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ack_rcvd,
  output logic              err,
  output logic              bus_busy,
  output logic              div_en,
  input  logic              tick_h,
  input  logic              tick_l,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_in
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                scl_oe_q, scl_oe_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                ack_rcvd_q, ack_rcvd_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                phase_q, phase_d;
  logic                mack_q, mack_d;
  logic                tick;

  assign div_en = (state_q == ST_START) || (state_q == ST_WRITE) ||
                  (state_q == ST_READ)  || (state_q == ST_STOP);
  // Ticks outside an active command are ignored entirely.
  assign tick = (tick_h | tick_l) & div_en;

  always_comb begin
    state_d    = state_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    err_d      = err_q;
    ack_rcvd_d = ack_rcvd_q;
    rx_data_d  = rx_data_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    mack_d     = mack_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if ((cmd != CMD_START) && !busy_q) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            case (cmd)
              CMD_START: state_d = ST_START;
              CMD_WRITE: begin
                state_d  = ST_WRITE;
                shift_d  = cmd_data;
                sda_oe_d = ~cmd_data[DATA_W-1];
              end
              CMD_READ: begin
                state_d  = ST_READ;
                sda_oe_d = 1'b0;
                mack_d   = cmd_ack;
              end
              default: begin
                // STOP: pull SDA low while SCL is still held low.
                state_d  = ST_STOP;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end
      end

      ST_START: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          case (bit_cnt_q)
            CNT_W'(0): sda_oe_d = 1'b0;
            CNT_W'(1): scl_oe_d = 1'b0;
            CNT_W'(2): sda_oe_d = 1'b1;
            default: begin
              scl_oe_d = 1'b1;
              busy_d   = 1'b1;
              err_d    = 1'b0;
              state_d  = ST_DONE;
            end
          endcase
        end
      end

      ST_WRITE: begin
        if (tick) begin
          if (!phase_q) begin
            scl_oe_d = 1'b0;
            phase_d  = 1'b1;
          end else begin
            phase_d  = 1'b0;
            scl_oe_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              ack_rcvd_d = sda_in;
              err_d      = 1'b0;
              state_d    = ST_DONE;
            end else begin
              shift_d   = {shift_q[DATA_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              // After the last data bit SDA is released for the slave's ACK.
              sda_oe_d  = (bit_cnt_q == LAST_DATA) ? 1'b0 : ~shift_d[DATA_W-1];
            end
          end
        end
      end

      ST_READ: begin
        if (tick) begin
          if (!phase_q) begin
            scl_oe_d = 1'b0;
            phase_d  = 1'b1;
          end else begin
            phase_d  = 1'b0;
            scl_oe_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d = shift_q;
              err_d     = 1'b0;
              state_d   = ST_DONE;
            end else begin
              shift_d   = {shift_q[DATA_W-2:0], sda_in};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == LAST_DATA) begin
                sda_oe_d = mack_q;
              end
            end
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          case (bit_cnt_q)
            CNT_W'(0): scl_oe_d = 1'b0;
            CNT_W'(1): sda_oe_d = 1'b0;
            default: begin
              // Third tick is only bus-free hold time.
              busy_d  = 1'b0;
              err_d   = 1'b0;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_rcvd_q <= 1'b0;
      rx_data_q  <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ack_rcvd_q <= ack_rcvd_d;
      rx_data_q  <= rx_data_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      mack_q     <= mack_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign bus_busy  = busy_q;
  assign err       = err_q;
  assign ack_rcvd  = ack_rcvd_q;
  assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Bench for i2c_bit_ctrl: 6-cycle divider model, open-drain slave model, bus-event monitor.
module tb_i2c_bit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_valid, cmd_ack, tick_h, tick_l, sda_in;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_ready, done, ack_rcvd, err, bus_busy, div_en, scl_oe, sda_oe;
  logic [7:0] rx_data;

  i2c_bit_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_data(cmd_data), .cmd_ack(cmd_ack), .done(done), .rx_data(rx_data),
    .ack_rcvd(ack_rcvd), .err(err), .bus_busy(bus_busy), .div_en(div_en),
    .tick_h(tick_h), .tick_l(tick_l), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  // Divider model: one tick on every 6th enabled cycle, alternating high/low strobes.
  int   div_cnt = 0;
  logic div_ph = 1'b0;
  logic rnd_h = 1'b0, rnd_l = 1'b0;
  logic div_tick;
  assign div_tick = (div_en === 1'b1) && (div_cnt == 5);
  always @(posedge clk) begin
    if (div_en !== 1'b1) div_cnt <= 0;
    else if (div_cnt == 5) div_cnt <= 0;
    else div_cnt <= div_cnt + 1;
    if (div_tick) div_ph <= ~div_ph;
  end
  assign tick_h = (div_tick & div_ph) | rnd_h;
  assign tick_l = (div_tick & ~div_ph) | rnd_l;

  // Slave: pattern bit 8 is the first SCL period of a command, 1 = pull SDA low.
  int         fall_cnt = 0, fall_base = 0, slv_idx;
  logic [8:0] slv_pat = '0;
  logic       slv_pull;
  always_comb begin
    slv_idx  = fall_cnt - fall_base;
    slv_pull = 1'b0;
    if (slv_idx >= 0 && slv_idx <= 8) slv_pull = slv_pat[8 - slv_idx];
  end
  assign sda_in = ~(sda_oe | slv_pull);

  // Monitor: SDA state at each SCL release, and SDA edges while SCL released.
  logic obs_bits[$];
  logic obs_cond[$];
  logic prev_scl = 1'bx, prev_sda = 1'bx;
  always @(negedge clk) begin
    if (prev_scl === 1'b1 && scl_oe === 1'b0) obs_bits.push_back(sda_oe);
    if (prev_scl === 1'b0 && scl_oe === 1'b1) fall_cnt <= fall_cnt + 1;
    if (prev_scl === 1'b0 && scl_oe === 1'b0 && (sda_oe === 1'b0 || sda_oe === 1'b1) &&
        (prev_sda === 1'b0 || prev_sda === 1'b1) && prev_sda !== sda_oe)
      obs_cond.push_back(sda_oe);
    prev_scl <= scl_oe;
    prev_sda <= sda_oe;
  end

  typedef struct {
    int         lat;
    int         en_cyc;
    int         sda_hi;
    logic       err;
    logic       busy;
    logic       ack;
    logic [7:0] rx;
  } res_t;

  res_t exp_q[$];
  logic exp_bits[$];
  int   bits_rd, cond_rd;
  int   n_checks = 0, n_pass = 0;
  logic [7:0] last_rx = 8'h00;
  logic       last_ack = 1'b0;

  localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;

  function automatic res_t mk_res(int lat, int en, logic e, logic b, logic a, logic [7:0] rx);
    res_t r;
    r.lat = lat; r.en_cyc = en; r.sda_hi = 0; r.err = e; r.busy = b; r.ack = a; r.rx = rx;
    return r;
  endfunction

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                        input logic [8:0] pat, output res_t r);
    @(negedge clk);
    slv_pat   = pat;
    fall_base = fall_cnt;
    bits_rd   = obs_bits.size();
    cond_rd   = obs_cond.size();
    cmd_valid = 1'b1; cmd = c; cmd_data = d; cmd_ack = a;
    r = mk_res(-1, 0, 1'bx, 1'bx, 1'bx, 8'hxx);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_ack   = ~a;
    for (int n = 1; n <= 500; n++) begin
      @(negedge clk);
      if (div_en === 1'b1) begin
        r.en_cyc++;
        if (sda_oe === 1'b1) r.sda_hi++;
      end
      if (done === 1'b1) begin
        r.lat = n; r.err = err; r.busy = bus_busy; r.ack = ack_rcvd; r.rx = rx_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd = 2'($urandom); cmd_data = 8'($urandom);
      cmd_ack = 1'($urandom); rnd_h = 1'($urandom); rnd_l = 1'($urandom);
      slv_pat = 9'($urandom);
    end
    @(negedge clk);
    n_checks++; if (scl_oe !== 1'b0) $display("FAIL reset_scl_oe: got %b want 0", scl_oe); else n_pass++;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (div_en !== 1'b0) $display("FAIL reset_div_en: got %b want 0", div_en); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (bus_busy !== 1'b0) $display("FAIL reset_bus_busy: got %b want 0", bus_busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_checks++; if ({ack_rcvd, rx_data} !== 9'h000) $display("FAIL reset_rx_ack: got %h want 000", {ack_rcvd, rx_data}); else n_pass++;
    rst = 1'b0; cmd_valid = 1'b0; rnd_h = 1'b0; rnd_l = 1'b0; slv_pat = '0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || div_en !== 1'b0) $display("FAIL post_reset_idle: got rdy=%b en=%b want rdy=1 en=0", cmd_ready, div_en); else n_pass++;
  endtask

  task automatic test_start(input logic repeated);
    res_t r, e;
    exp_q.push_back(mk_res(25, 24, 1'b0, 1'b1, last_ack, last_rx));
    do_cmd(C_START, 8'h00, 1'b0, 9'h000, r);
    e = exp_q.pop_front();
    n_checks++; if (r.lat !== e.lat) $display("FAIL start_latency: got %0d want %0d", r.lat, e.lat); else n_pass++;
    n_checks++; if (r.en_cyc !== e.en_cyc) $display("FAIL start_div_en_cycles: got %0d want %0d", r.en_cyc, e.en_cyc); else n_pass++;
    n_checks++; if (r.busy !== e.busy || r.err !== e.err) $display("FAIL start_busy_err: got %b%b want %b%b", r.busy, r.err, e.busy, e.err); else n_pass++;
    n_checks++;
    if (obs_cond.size() != cond_rd + 1 || obs_cond[cond_rd] !== 1'b1)
      $display("FAIL start_condition: got %0d events want one SDA fall with SCL high", obs_cond.size() - cond_rd);
    else n_pass++;
    // Repeated START must release SDA before releasing SCL; from a free bus SCL never moves up.
    n_checks++;
    if (repeated && (obs_bits.size() != bits_rd + 1 || obs_bits[bits_rd] !== 1'b0))
      $display("FAIL rstart_sda_before_scl: got %0d scl rises want 1 with sda released", obs_bits.size() - bits_rd);
    else if (!repeated && obs_bits.size() != bits_rd)
      $display("FAIL start_scl_rises: got %0d want 0", obs_bits.size() - bits_rd);
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({scl_oe, sda_oe} !== 2'b11) $display("FAIL start_hold_lines: got %b want 11", {scl_oe, sda_oe}); else n_pass++;
  endtask

  task automatic test_write(input logic [7:0] d, input logic slave_ack_low);
    res_t r, e;
    logic eb;
    logic exp_ack;
    exp_ack = ~slave_ack_low;
    exp_q.push_back(mk_res(109, 108, 1'b0, 1'b1, exp_ack, last_rx));
    for (int i = 7; i >= 0; i--) exp_bits.push_back(~d[i]);
    exp_bits.push_back(1'b0);
    do_cmd(C_WRITE, d, 1'b0, {8'h00, slave_ack_low}, r);
    e = exp_q.pop_front();
    n_checks++; if (r.lat !== e.lat) $display("FAIL write_latency: got %0d want %0d", r.lat, e.lat); else n_pass++;
    n_checks++; if (r.en_cyc !== e.en_cyc) $display("FAIL write_div_en_cycles: got %0d want %0d", r.en_cyc, e.en_cyc); else n_pass++;
    n_checks++; if (r.ack !== e.ack) $display("FAIL write_ack_rcvd: got %b want %b", r.ack, e.ack); else n_pass++;
    n_checks++; if (r.err !== 1'b0 || r.rx !== e.rx) $display("FAIL write_err_rx: got %b/%h want 0/%h", r.err, r.rx, e.rx); else n_pass++;
    n_checks++; if (obs_bits.size() - bits_rd != 9) $display("FAIL write_scl_pulses: got %0d want 9", obs_bits.size() - bits_rd); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      eb = exp_bits.pop_front();
      n_checks++;
      if (obs_bits.size() <= bits_rd + i || obs_bits[bits_rd + i] !== eb)
        $display("FAIL write_bit%0d: got sda_oe=%b want %b", i, (obs_bits.size() > bits_rd + i) ? obs_bits[bits_rd + i] : 1'bx, eb);
      else n_pass++;
    end
    n_checks++; if (obs_cond.size() != cond_rd) $display("FAIL write_spurious_cond: got %0d want 0", obs_cond.size() - cond_rd); else n_pass++;
    last_ack = exp_ack;
  endtask

  task automatic test_read(input logic [7:0] d, input logic a);
    res_t r, e;
    logic eb;
    exp_q.push_back(mk_res(109, 108, 1'b0, 1'b1, last_ack, d));
    for (int i = 0; i < 8; i++) exp_bits.push_back(1'b0);
    exp_bits.push_back(a);
    do_cmd(C_READ, 8'h00, a, {~d, 1'b0}, r);
    e = exp_q.pop_front();
    n_checks++; if (r.lat !== e.lat) $display("FAIL read_latency: got %0d want %0d", r.lat, e.lat); else n_pass++;
    n_checks++; if (r.rx !== e.rx) $display("FAIL read_rx_data: got %h want %h", r.rx, e.rx); else n_pass++;
    n_checks++; if (r.err !== 1'b0 || r.ack !== e.ack) $display("FAIL read_err_ack: got %b/%b want 0/%b", r.err, r.ack, e.ack); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      eb = exp_bits.pop_front();
      n_checks++;
      if (obs_bits.size() <= bits_rd + i || obs_bits[bits_rd + i] !== eb)
        $display("FAIL read_bit%0d: got sda_oe=%b want %b", i, (obs_bits.size() > bits_rd + i) ? obs_bits[bits_rd + i] : 1'bx, eb);
      else n_pass++;
    end
    if (!a) begin
      n_checks++; if (r.sda_hi != 0) $display("FAIL read_nack_sda: got %0d cycles sda_oe=1 want 0", r.sda_hi); else n_pass++;
    end
    last_rx = d;
  endtask

  task automatic test_stop();
    res_t r, e;
    exp_q.push_back(mk_res(19, 18, 1'b0, 1'b0, last_ack, last_rx));
    do_cmd(C_STOP, 8'h00, 1'b0, 9'h000, r);
    e = exp_q.pop_front();
    n_checks++; if (r.lat !== e.lat) $display("FAIL stop_latency: got %0d want %0d", r.lat, e.lat); else n_pass++;
    n_checks++; if (r.busy !== 1'b0 || r.err !== 1'b0) $display("FAIL stop_busy_err: got %b%b want 00", r.busy, r.err); else n_pass++;
    n_checks++;
    if (obs_bits.size() != bits_rd + 1 || obs_bits[bits_rd] !== 1'b1)
      $display("FAIL stop_scl_rise_sda_low: got %0d rises want 1 with sda held low", obs_bits.size() - bits_rd);
    else n_pass++;
    n_checks++;
    if (obs_cond.size() != cond_rd + 1 || obs_cond[cond_rd] !== 1'b0)
      $display("FAIL stop_condition: got %0d events want one SDA rise with SCL high", obs_cond.size() - cond_rd);
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL stop_lines_free: got %b want 00", {scl_oe, sda_oe}); else n_pass++;
  endtask

  task automatic test_illegal();
    res_t r, e;
    logic [1:0] c;
    for (int k = 1; k <= 3; k++) begin
      c = 2'(k);
      exp_q.push_back(mk_res(1, 0, 1'b1, 1'b0, last_ack, last_rx));
      do_cmd(c, 8'hFF, 1'b1, 9'h000, r);
      e = exp_q.pop_front();
      n_checks++; if (r.lat !== e.lat) $display("FAIL illegal%0d_latency: got %0d want %0d", k, r.lat, e.lat); else n_pass++;
      n_checks++; if (r.en_cyc !== 0) $display("FAIL illegal%0d_div_en: got %0d cycles want 0", k, r.en_cyc); else n_pass++;
      n_checks++; if (r.err !== 1'b1) $display("FAIL illegal%0d_err: got %b want 1", k, r.err); else n_pass++;
      n_checks++; if (r.rx !== e.rx || r.ack !== e.ack) $display("FAIL illegal%0d_rx_ack: got %h/%b want %h/%b", k, r.rx, r.ack, e.rx, e.ack); else n_pass++;
      n_checks++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL illegal%0d_lines: got %b want 00", k, {scl_oe, sda_oe}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_WRITE; cmd_data = 8'h81;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if (div_en !== 1'b1) $display("FAIL midreset_active: got div_en=%b want 1", div_en); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL midreset_lines: got %b want 00", {scl_oe, sda_oe}); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1 || div_en !== 1'b0) $display("FAIL midreset_ready: got rdy=%b en=%b want 1/0", cmd_ready, div_en); else n_pass++;
    n_checks++; if (bus_busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_busy_done: got %b%b want 00", bus_busy, done); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_data = 8'h00; cmd_ack = 1'b0;
    test_reset();
    test_start(1'b0);
    test_write(8'hA5, 1'b1);
    test_write(8'h00, 1'b0);
    test_read(8'h3C, 1'b0);
    test_read(8'hC3, 1'b1);
    test_start(1'b1);
    test_stop();
    test_illegal();
    test_start(1'b0);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
